// File: rtl/c3po_dispatch.sv
// c3po_dispatch: routes one packet stream to PORTS_P output ports by packet ID.
// Each port runs a packet-level forward/drop FSM, keeps two mode-selectable
// statistics counters plus a saturating drop counter, and exposes its
// configuration and counters through the C-3PO register handshake.
module c3po_dispatch #(
  parameter int PORTS_P     = 4,
  parameter int CNT_SIZE_P  = 16,
  parameter int ADDR_SIZE_P = 6,
  parameter int DATA_W_P    = 1280,
  parameter int ID_W_P      = 4,
  parameter int VBC_W_P     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  // register handshake
  input  logic [ADDR_SIZE_P-1:0]         reg_addr,
  input  logic                           reg_req,
  input  logic                           reg_rd_wr,
  input  logic [31:0]                    reg_write_val,
  output logic [31:0]                    reg_read_val,
  output logic                           reg_ack,
  // input beat stream
  input  logic                           val,
  input  logic                           sop,
  input  logic                           eop,
  input  logic [ID_W_P-1:0]              id,
  input  logic [VBC_W_P-1:0]             vbc,
  input  logic [DATA_W_P-1:0]            data,
  output logic                           in_ready,
  // per-port outputs
  input  logic [PORTS_P-1:0]             port_ready,
  output logic [PORTS_P-1:0]             o_val,
  output logic [PORTS_P-1:0]             o_sop,
  output logic [PORTS_P-1:0]             o_eop,
  output logic [PORTS_P*VBC_W_P-1:0]     o_vbc,
  output logic [PORTS_P*DATA_W_P-1:0]    o_data,
  output logic [PORTS_P*CNT_SIZE_P-1:0]  cnt0_val,
  output logic [PORTS_P*CNT_SIZE_P-1:0]  cnt1_val,
  output logic [PORTS_P*CNT_SIZE_P-1:0]  drop_val
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Adder is wide enough for either operand plus a carry, so saturation can
  // be detected without losing the overflow bit.
  localparam int SUM_W = ((CNT_SIZE_P > VBC_W_P) ? CNT_SIZE_P : VBC_W_P) + 1;
  localparam logic [CNT_SIZE_P-1:0] CNT_MAX = '1;

  // Next counter value: optional clear-on-read, then add, then wrap or clamp.
  // A clear in the same cycle as an increment leaves exactly the increment.
  function automatic logic [CNT_SIZE_P-1:0] cnt_step(
    input logic [CNT_SIZE_P-1:0] cur,
    input logic                  clr,
    input logic [VBC_W_P-1:0]    inc,
    input logic                  sat
  );
    logic [SUM_W-1:0] sum;
    sum = (clr ? '0 : SUM_W'(cur)) + SUM_W'(inc);
    if (sat && (sum > SUM_W'(CNT_MAX))) return CNT_MAX;
    return sum[CNT_SIZE_P-1:0];
  endfunction

  // Increment for a statistics counter: bytes on every forwarded beat, or one
  // packet on a forwarded eop beat.
  function automatic logic [VBC_W_P-1:0] inc_amt(
    input logic               byte_mode,
    input logic               fwd_b,
    input logic               eop_b,
    input logic [VBC_W_P-1:0] nbytes
  );
    if (byte_mode) return fwd_b ? nbytes : '0;
    return VBC_W_P'(fwd_b & eop_b);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q [PORTS_P];
  state_e                state_d [PORTS_P];

  logic [PORTS_P-1:0]    cfg_en_q, cfg_m0_q, cfg_m1_q, cfg_sat_q, cfg_err_q;
  logic [ID_W_P-1:0]     cfg_id_q [PORTS_P];

  logic [CNT_SIZE_P-1:0] cnt0_q [PORTS_P], cnt0_d [PORTS_P];
  logic [CNT_SIZE_P-1:0] cnt1_q [PORTS_P], cnt1_d [PORTS_P];
  logic [CNT_SIZE_P-1:0] drop_q [PORTS_P], drop_d [PORTS_P];

  logic [PORTS_P-1:0]    o_val_q, o_sop_q, o_eop_q;
  logic [VBC_W_P-1:0]    o_vbc_q  [PORTS_P];
  logic [DATA_W_P-1:0]   o_data_q [PORTS_P];

  logic                  ack_q;
  logic [31:0]           rd_val_q;

  // ---------------------------------------------------------------------------
  // Beat decode
  // ---------------------------------------------------------------------------
  logic [PORTS_P-1:0]    sel;
  logic                  hit;
  logic                  accept;
  logic [PORTS_P-1:0]    fwd;
  logic [PORTS_P-1:0]    drop_inc;
  logic [PORTS_P-1:0]    err_set;

  // Match the beat to a port, derive in_ready, and decide each port's action.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the branches can leave one unassigned and infer a latch.
    sel      = '0;
    hit      = 1'b0;
    in_ready = 1'b1;
    fwd      = '0;
    drop_inc = '0;
    err_set  = '0;

    // Lowest-index match wins.
    for (int p = 0; p < PORTS_P; p++) begin
      if (!hit && (id == cfg_id_q[p])) begin
        hit    = 1'b1;
        sel[p] = 1'b1;
      end
    end

    // Only a port that may forward this beat applies downstream backpressure.
    for (int p = 0; p < PORTS_P; p++) begin
      if (sel[p] && ((state_q[p] == ST_FWD) ||
                     ((state_q[p] == ST_IDLE) && cfg_en_q[p]))) begin
        in_ready = port_ready[p];
      end
    end

    accept = val & in_ready;

    for (int p = 0; p < PORTS_P; p++) begin
      state_d[p] = state_q[p];
      if (accept && sel[p]) begin
        if (sop) begin
          // A sop always restarts the decision; mid-packet it is an error.
          err_set[p] = (state_q[p] != ST_IDLE);
          fwd[p]     = cfg_en_q[p];
          drop_inc[p] = ~cfg_en_q[p] & eop;
          if (eop)              state_d[p] = ST_IDLE;
          else if (cfg_en_q[p]) state_d[p] = ST_FWD;
          else                  state_d[p] = ST_DROP;
        end else begin
          case (state_q[p])
            ST_FWD: begin
              fwd[p] = 1'b1;
              if (eop) state_d[p] = ST_IDLE;
            end
            ST_DROP: begin
              if (eop) begin
                drop_inc[p] = 1'b1;
                state_d[p]  = ST_IDLE;
              end
            end
            default: begin
              // Stray beat outside a packet.
              err_set[p]  = 1'b1;
              drop_inc[p] = 1'b1;
            end
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic                     serve;
  logic [ADDR_SIZE_P+1:0]   addr_x;
  logic [ADDR_SIZE_P-1:0]   reg_port;
  logic [1:0]               reg_off;
  logic                     reg_hit;
  logic [31:0]              rd_data;
  logic [PORTS_P-1:0]       clr0, clr1, clrd, wr_cfg;

  // Decode the register address, build read data and the clear/write strobes.
  always_comb begin
    serve    = reg_req & ~ack_q;
    addr_x   = {2'b00, reg_addr};
    reg_port = addr_x[ADDR_SIZE_P+1:2];
    reg_off  = addr_x[1:0];
    reg_hit  = int'(reg_port) < PORTS_P;
    rd_data  = '0;
    clr0     = '0;
    clr1     = '0;
    clrd     = '0;
    wr_cfg   = '0;
    for (int p = 0; p < PORTS_P; p++) begin
      if (reg_hit && (int'(reg_port) == p)) begin
        case (reg_off)
          2'd0: begin
            rd_data[0]               = cfg_en_q[p];
            rd_data[1]               = cfg_m0_q[p];
            rd_data[2]               = cfg_m1_q[p];
            rd_data[3]               = cfg_sat_q[p];
            rd_data[ID_W_P+7:8]      = cfg_id_q[p];
            rd_data[31]              = cfg_err_q[p];
            wr_cfg[p]                = serve & ~reg_rd_wr;
          end
          2'd1: begin
            rd_data = 32'(cnt0_q[p]);
            clr0[p] = serve & reg_rd_wr;
          end
          2'd2: begin
            rd_data = 32'(cnt1_q[p]);
            clr1[p] = serve & reg_rd_wr;
          end
          2'd3: begin
            rd_data = 32'(drop_q[p]);
            clrd[p] = serve & reg_rd_wr;
          end
        endcase
      end
    end
  end

  // Counter next-state: clear-on-read merged with this cycle's increment.
  always_comb begin
    for (int p = 0; p < PORTS_P; p++) begin
      cnt0_d[p] = cnt_step(cnt0_q[p], clr0[p],
                           inc_amt(cfg_m0_q[p], fwd[p], eop, vbc), cfg_sat_q[p]);
      cnt1_d[p] = cnt_step(cnt1_q[p], clr1[p],
                           inc_amt(cfg_m1_q[p], fwd[p], eop, vbc), cfg_sat_q[p]);
      drop_d[p] = cnt_step(drop_q[p], clrd[p], VBC_W_P'(drop_inc[p]), 1'b1);
    end
  end

  // Per-port FSMs and registered forwarding outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (reset) begin
      o_val_q <= '0;
      o_sop_q <= '0;
      o_eop_q <= '0;
      for (int p = 0; p < PORTS_P; p++) begin
        state_q[p]  <= ST_IDLE;
        // NOTE: the wide output data registers are reset too, because the
        // port outputs must read 0 straight out of reset.
        o_vbc_q[p]  <= '0;
        o_data_q[p] <= '0;
      end
    end else begin
      o_val_q <= fwd;
      o_sop_q <= fwd & {PORTS_P{sop}};
      o_eop_q <= fwd & {PORTS_P{eop}};
      for (int p = 0; p < PORTS_P; p++) begin
        state_q[p] <= state_d[p];
        if (fwd[p]) begin
          o_vbc_q[p]  <= vbc;
          o_data_q[p] <= data;
        end
      end
    end
  end

  // Statistics and drop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PORTS_P; p++) begin
        cnt0_q[p] <= '0;
        cnt1_q[p] <= '0;
        drop_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PORTS_P; p++) begin
        cnt0_q[p] <= cnt0_d[p];
        cnt1_q[p] <= cnt1_d[p];
        drop_q[p] <= drop_d[p];
      end
    end
  end

  // Register handshake: one-cycle ack, read data only during ack, CFG writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q     <= 1'b0;
      rd_val_q  <= '0;
      cfg_en_q  <= '0;
      cfg_m0_q  <= '0;
      cfg_m1_q  <= '1;
      cfg_sat_q <= '0;
      cfg_err_q <= '0;
      for (int p = 0; p < PORTS_P; p++) begin
        cfg_id_q[p] <= ID_W_P'(p);
      end
    end else begin
      ack_q    <= serve;
      rd_val_q <= (serve & reg_rd_wr) ? rd_data : '0;
      for (int p = 0; p < PORTS_P; p++) begin
        if (wr_cfg[p]) begin
          cfg_en_q[p]  <= reg_write_val[0];
          cfg_m0_q[p]  <= reg_write_val[1];
          cfg_m1_q[p]  <= reg_write_val[2];
          cfg_sat_q[p] <= reg_write_val[3];
          cfg_id_q[p]  <= reg_write_val[ID_W_P+7:8];
        end
        // A new error in the same cycle as a clear is kept.
        if (err_set[p])                          cfg_err_q[p] <= 1'b1;
        else if (wr_cfg[p] && reg_write_val[31]) cfg_err_q[p] <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  assign reg_ack      = ack_q;
  assign reg_read_val = rd_val_q;
  assign o_val        = o_val_q;
  assign o_sop        = o_sop_q;
  assign o_eop        = o_eop_q;

  for (genvar g = 0; g < PORTS_P; g++) begin : g_pack
    assign o_vbc   [g*VBC_W_P    +: VBC_W_P]    = o_vbc_q[g];
    assign o_data  [g*DATA_W_P   +: DATA_W_P]   = o_data_q[g];
    assign cnt0_val[g*CNT_SIZE_P +: CNT_SIZE_P] = cnt0_q[g];
    assign cnt1_val[g*CNT_SIZE_P +: CNT_SIZE_P] = cnt1_q[g];
    assign drop_val[g*CNT_SIZE_P +: CNT_SIZE_P] = drop_q[g];
  end

  // Bits [7:4] and the upper CFG bits of the write word have no function.
  logic unused_wr;
  assign unused_wr = ^reg_write_val;

endmodule
